pc_fetch_ctrl: RTL and testbench

Program-counter and next-address controller for the single-cycle MIPS core. It produces `PC_plus_4` for `executs32` and consumes that unit's `Addr_Result`/`Zero` results to resolve branches, jumps and `jr` into the next fetch address. It drives the synchronous instruction-memory word address and latches the `jal` link address. It also handles pipeline holds requested by slow memory-mapped I/O.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/next_pc_sel.sv | 32 +++
 rtl/pc_fetch_ctrl.sv | 114 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS core: fetch FSM states and core constants.
// IFETCH_MISALIGN_TRAP_EN adds the TRAP state to ifetch_state_t.
package cpu_pkg;

  localparam logic [31:0] WORD_BYTES       = 32'd4;
  localparam logic [4:0]  LINK_REG         = 5'd31;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

`ifdef IFETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HOLD,
    ST_TRAP
  } ifetch_state_t;
`else
  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HOLD
  } ifetch_state_t;
`endif

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority mux: jr > j/jal > taken branch > sequential.
module next_pc_sel (
  input  logic [31:0] pc_plus_4,
  input  logic [31:0] addr_result,
  input  logic        zero,
  input  logic [31:0] read_data_1,
  input  logic [25:0] instruction_low,
  input  logic        branch,
  input  logic        nbranch,
  input  logic        jmp,
  input  logic        jal,
  input  logic        jr,
  output logic [31:0] next_pc,
  output logic        branch_taken,
  output logic        link_we
);

  assign branch_taken = (branch & zero) | (nbranch & ~zero);
  // jal only links when it is the winning source; jr overrides it.
  assign link_we      = jal & ~jr;

  always_comb begin
    next_pc = pc_plus_4;
    if (jr)
      next_pc = read_data_1;
    else if (jmp | jal)
      next_pc = {pc_plus_4[31:28], instruction_low, 2'b00};
    else if (branch_taken)
      next_pc = addr_result;
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC / next-address controller: boot FSM, stall hold, PC and jal link registers.
// IFETCH_MISALIGN_TRAP_EN adds misalign_trap and a sticky TRAP state for unaligned targets.
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_AW  = 14
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        Addr_Result,
  input  logic               Zero,
  input  logic [31:0]        Read_data_1,
  input  logic [25:0]        Instruction_low,
  input  logic               Branch,
  input  logic               nBranch,
  input  logic               Jmp,
  input  logic               Jal,
  input  logic               Jr,
  input  logic               stall,
  output logic [31:0]        PC,
  output logic [31:0]        PC_plus_4,
  output logic [31:0]        link_addr,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               inst_valid
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic               misalign_trap
`endif
);

  ifetch_state_t state, state_nxt;
  logic [31:0]   sel_pc;
  logic [31:0]   next_pc;
  logic          advance;
  logic          link_we;
  logic          unused_branch_taken;

  assign PC_plus_4 = PC + WORD_BYTES;

  next_pc_sel u_next_pc_sel (
    .pc_plus_4       (PC_plus_4),
    .addr_result     (Addr_Result),
    .zero            (Zero),
    .read_data_1     (Read_data_1),
    .instruction_low (Instruction_low),
    .branch          (Branch),
    .nbranch         (nBranch),
    .jmp             (Jmp),
    .jal             (Jal),
    .jr              (Jr),
    .next_pc         (sel_pc),
    .branch_taken    (unused_branch_taken),
    .link_we         (link_we)
  );

  // next_pc defaults to PC so the ROM re-reads the current word whenever PC is not advancing.
  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    next_pc   = PC;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN, ST_HOLD: begin
        if (stall) begin
          state_nxt = ST_HOLD;
        end else begin
`ifdef IFETCH_MISALIGN_TRAP_EN
          if (sel_pc[1:0] != 2'b00) begin
            state_nxt = ST_TRAP;
          end else begin
            state_nxt = ST_RUN;
            advance   = 1'b1;
            next_pc   = sel_pc;
          end
`else
          state_nxt = ST_RUN;
          advance   = 1'b1;
          next_pc   = sel_pc & ~32'd3;
`endif
        end
      end
      default: state_nxt = state;
    endcase
  end

  assign imem_addr  = next_pc[IMEM_AW+1:2];
  assign inst_valid = (state == ST_RUN) || (state == ST_HOLD);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_BOOT;
      PC        <= RESET_PC;
      link_addr <= '0;
    end else begin
      state <= state_nxt;
      if (advance) begin
        PC <= next_pc;
        if (link_we)
          link_addr <= PC_plus_4;
      end
    end
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clock) begin
    if (reset)
      misalign_trap <= 1'b0;
    else if (state_nxt == ST_TRAP)
      misalign_trap <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed test-plan cases plus randomized control streams
// checked against a behavioural next-PC model. Honours IFETCH_MISALIGN_TRAP_EN.
module tb_pc_fetch_ctrl;

  localparam int unsigned IMEM_AW  = 14;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic               clock = 1'b0;
  logic               reset;
  logic [31:0]        Addr_Result;
  logic               Zero;
  logic [31:0]        Read_data_1;
  logic [25:0]        Instruction_low;
  logic               Branch, nBranch, Jmp, Jal, Jr, stall;
  logic [31:0]        PC, PC_plus_4, link_addr;
  logic [IMEM_AW-1:0] imem_addr;
  logic               inst_valid;
  logic               misalign_trap;

  pc_fetch_ctrl #(.RESET_PC(RESET_PC), .IMEM_AW(IMEM_AW)) dut (
    .clock           (clock),
    .reset           (reset),
    .Addr_Result     (Addr_Result),
    .Zero            (Zero),
    .Read_data_1     (Read_data_1),
    .Instruction_low (Instruction_low),
    .Branch          (Branch),
    .nBranch         (nBranch),
    .Jmp             (Jmp),
    .Jal             (Jal),
    .Jr              (Jr),
    .stall           (stall),
    .PC              (PC),
    .PC_plus_4       (PC_plus_4),
    .link_addr       (link_addr),
    .imem_addr       (imem_addr),
    .inst_valid      (inst_valid)
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    .misalign_trap   (misalign_trap)
`endif
  );

`ifndef IFETCH_MISALIGN_TRAP_EN
  assign misalign_trap = 1'b0;
`endif

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state: architectural PC, link register, boot cycle pending, trapped.
  logic [31:0] m_pc, m_link;
  bit          m_boot, m_trap;

  function automatic logic [31:0] m_target();
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    if (Jr)                                    return Read_data_1;
    if (Jmp || Jal)                            return {seq[31:28], Instruction_low, 2'b00};
    if ((Branch && Zero) || (nBranch && !Zero)) return Addr_Result;
    return seq;
  endfunction

  task automatic idle_inputs();
    Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jr = 0; stall = 0; Zero = 0;
    Addr_Result = '0; Read_data_1 = '0; Instruction_low = '0;
  endtask

  // One clock: check combinational outputs for the current inputs, clock, then check state.
  task automatic cycle();
    bit          adv, trap_now;
    logic [31:0] tgt, nxt;
    #1;
    adv      = !m_boot && !m_trap && !stall;
    trap_now = 0;
    tgt      = m_target();
`ifdef IFETCH_MISALIGN_TRAP_EN
    if (adv && tgt[1:0] != 2'b00) begin
      adv      = 0;
      trap_now = 1;
    end
`else
    tgt[1:0] = 2'b00;
`endif
    nxt = adv ? tgt : m_pc;
    check("imem_addr", 32'(imem_addr), 32'(nxt[IMEM_AW+1:2]));
    check("pc_plus_4", PC_plus_4, m_pc + 32'd4);
    @(posedge clock);
    #1;
    if (adv) begin
      if (Jal && !Jr) m_link = m_pc + 32'd4;
      m_pc = nxt;
    end
    if (trap_now) m_trap = 1;
    m_boot = 0;
    check("pc", PC, m_pc);
    check("link_addr", link_addr, m_link);
    check("inst_valid", 32'(inst_valid), 32'(!m_trap));
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("misalign_trap", 32'(misalign_trap), 32'(m_trap));
`endif
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clock);
    #1;
    reset = 0;
    idle_inputs();
    m_pc = RESET_PC; m_link = '0; m_boot = 1; m_trap = 0;
    #1;
    check("rst_pc", PC, RESET_PC);
    check("rst_pc_plus_4", PC_plus_4, RESET_PC + 32'd4);
    check("rst_link", link_addr, 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'h0);
    check("rst_imem_addr", 32'(imem_addr), 32'(RESET_PC[IMEM_AW+1:2]));
    check("rst_trap", 32'(misalign_trap), 32'h0);
  endtask

  task automatic jump_to(input logic [31:0] addr);
    idle_inputs();
    Jr = 1; Read_data_1 = addr;
    cycle();
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    m_pc = RESET_PC; m_link = '0; m_boot = 1; m_trap = 0;

    // Boot then sequential fetch.
    do_reset();
    cycle();
    check("boot_pc", PC, 32'h0);
    check("boot_valid", 32'(inst_valid), 32'h1);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      check("seq_pc", PC, 32'(4 * i));
    end

    // Branch taken / not taken / nBranch.
    jump_to(32'h10);
    Branch = 1; Zero = 1; Addr_Result = 32'h40;
    cycle();
    check("beq_taken", PC, 32'h40);
    jump_to(32'h10);
    Branch = 1; Zero = 0; Addr_Result = 32'h40;
    cycle();
    check("beq_not_taken", PC, 32'h14);
    idle_inputs();
    nBranch = 1; Zero = 0; Addr_Result = 32'h80;
    cycle();
    check("bne_taken", PC, 32'h80);

    // jal target and link.
    jump_to(32'h1000_0020);
    Jal = 1; Instruction_low = 26'h000_0010;
    cycle();
    check("jal_pc", PC, 32'h1000_0040);
    check("jal_link", link_addr, 32'h1000_0024);

    // Priority: jr beats jump and branch.
    idle_inputs();
    Jr = 1; Jmp = 1; Branch = 1; Zero = 1;
    Read_data_1 = 32'h200; Addr_Result = 32'h300; Instruction_low = 26'h123;
    cycle();
    check("prio_pc", PC, 32'h200);

    // Three-cycle stall over a taken branch.
    jump_to(32'h100);
    Branch = 1; Zero = 1; Addr_Result = 32'h500; stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_pc", PC, 32'h100);
      check("stall_imem", 32'(imem_addr), 32'h40);
    end
    stall = 0;
    cycle();
    check("post_stall_pc", PC, 32'h500);

    // PC_plus_4 wraps with no side effect.
    jump_to(32'hFFFF_FFFC);
    check("wrap_pc_plus_4", PC_plus_4, 32'h0);
    cycle();
    check("wrap_pc", PC, 32'h0);

    // Reset dominates a jal and a stall on the same edge; stall in BOOT is ignored.
    Jal = 1; Instruction_low = 26'h3FF_FFFF; stall = 1;
    do_reset();
    stall = 1;
    cycle();
    check("boot_stall_valid", 32'(inst_valid), 32'h1);
    stall = 0;

    // Randomized streams against the model.
    for (int i = 0; i < 3000; i++) begin
      Branch          = ($urandom_range(0, 3) == 0);
      nBranch         = ($urandom_range(0, 3) == 0);
      Jmp             = ($urandom_range(0, 7) == 0);
      Jal             = ($urandom_range(0, 7) == 0);
      Jr              = ($urandom_range(0, 9) == 0);
      Zero            = $urandom_range(0, 1) == 1;
      stall           = ($urandom_range(0, 3) == 0);
      Addr_Result     = $urandom() & 32'hFFFF_FFFC;
      Read_data_1     = $urandom() & 32'hFFFF_FFFC;
      Instruction_low = 26'($urandom());
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cycle();
      end
    end

    // Misaligned jr.
    idle_inputs();
    jump_to(32'h200);
    Jr = 1; Read_data_1 = 32'h202;
    cycle();
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("misalign_trap_set", 32'(misalign_trap), 32'h1);
    check("misalign_pc_frozen", PC, 32'h200);
    idle_inputs();
    cycle();
    check("trap_sticky_pc", PC, 32'h200);
    check("trap_valid", 32'(inst_valid), 32'h0);
`else
    check("misalign_pc", PC, 32'h200);
`endif
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
